// File: rtl/rf_issue_scoreboard.sv
// Purpose: register-file issue scoreboard with per-register busy bits, an inflight limit and a branch wait state.
// Latency: dec_ready is combinational; issue_valid/issue_wr/flush are registered and follow an issue by 1 cycle.
// Backpressure: dec_ready drops on RAW/WAW hazards, a full inflight count, reset, or while a branch is unresolved.
//
// Ports:
//   clk, reset                     clock; synchronous active-high reset
//   dec_valid / dec_ready          decoded instruction handshake (issue = dec_valid && dec_ready)
//   rf_rd1, rf_rd2                 source register addresses
//   rf_wr, rf_wr_enable            destination register and write flag
//   is_branch, is_jump             control-transfer flags of the decoded instruction
//   wb_valid, wb_addr              writeback completion
//   br_resolve, br_taken           branch resolution
//   issue_valid, issue_wr          registered copy of the last issue
//   flush                          one-cycle pulse after a taken branch resolves
//   wb_err                         sticky flag: writeback to a register that was not busy (or to r0)
//
// Build option: define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release its
// register for the hazard check and free one slot for the full check.

module rf_issue_scoreboard #(
    parameter int RF_ADDR_WIDTH = 9,
    parameter int MAX_INFLIGHT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid,
    input  logic [RF_ADDR_WIDTH-1:0] rf_rd1,
    input  logic [RF_ADDR_WIDTH-1:0] rf_rd2,
    input  logic [RF_ADDR_WIDTH-1:0] rf_wr,
    input  logic                     rf_wr_enable,
    input  logic                     is_branch,
    input  logic                     is_jump,
    input  logic                     wb_valid,
    input  logic [RF_ADDR_WIDTH-1:0] wb_addr,
    input  logic                     br_resolve,
    input  logic                     br_taken,
    output logic                     dec_ready,
    output logic                     issue_valid,
    output logic [RF_ADDR_WIDTH-1:0] issue_wr,
    output logic                     flush,
    output logic                     wb_err
);

    localparam int NUM_REGS = 2 ** RF_ADDR_WIDTH;
    localparam int CNT_W    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    typedef enum logic {
        ST_RUN,
        ST_BR_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_REGS-1:0]        busy_q, busy_d;
    logic [CNT_W-1:0]           inflight_q, inflight_d;
    logic                       issue_valid_q, issue_valid_d;
    logic [RF_ADDR_WIDTH-1:0]   issue_wr_q, issue_wr_d;
    logic                       flush_q, flush_d;
    logic                       wb_err_q, wb_err_d;

    logic wb_hit;      // writeback to a register that is currently busy
    logic wb_bad;      // writeback to r0 or to a register that is not busy
    logic wb_frees;    // writeback that may be credited to this cycle's checks
    logic hazard;
    logic full;
    logic issue;
    logic set_busy;

    // Writeback classification; r0 is never busy so it always lands in wb_bad.
    always_comb begin
        wb_hit   = wb_valid && (wb_addr != '0) && busy_q[wb_addr];
        wb_bad   = wb_valid && !wb_hit;
`ifdef SCOREBOARD_WB_BYPASS_EN
        wb_frees = wb_hit;
`else
        wb_frees = 1'b0;
`endif
    end

    // Hazard and full checks. With the bypass, the register being written back
    // is seen as already free, and the slot it frees counts against the limit.
    always_comb begin
        logic rd1_busy;
        logic rd2_busy;
        logic wr_busy;
        rd1_busy = busy_q[rf_rd1] && !(wb_frees && (wb_addr == rf_rd1));
        rd2_busy = busy_q[rf_rd2] && !(wb_frees && (wb_addr == rf_rd2));
        wr_busy  = busy_q[rf_wr]  && !(wb_frees && (wb_addr == rf_wr));
        hazard   = rd1_busy || rd2_busy || (rf_wr_enable && wr_busy);
        full     = rf_wr_enable && (rf_wr != '0) && (inflight_q == MAX_CNT) && !wb_frees;
    end

    assign dec_ready = !reset && (state_q == ST_RUN) && !hazard && !full;
    assign issue     = dec_valid && dec_ready;
    assign set_busy  = issue && rf_wr_enable && (rf_wr != '0);

    always_comb begin
        busy_d        = busy_q;
        inflight_d    = inflight_q;
        state_d       = state_q;
        issue_valid_d = issue;
        issue_wr_d    = issue ? rf_wr : issue_wr_q;
        flush_d       = 1'b0;
        wb_err_d      = wb_err_q || wb_bad;

        // Clear before set so a same-register set/clear leaves the bit set.
        if (wb_hit) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (set_busy) begin
            busy_d[rf_wr] = 1'b1;
        end

        // Set and clear together leave the count unchanged; the bounds
        // guards keep the counter from wrapping in either direction.
        if (set_busy && !wb_hit && (inflight_q != MAX_CNT)) begin
            inflight_d = inflight_q + 1'b1;
        end else if (wb_hit && !set_busy && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (issue && (is_branch || is_jump)) begin
                    state_d = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (br_resolve) begin
                    state_d = ST_RUN;
                    flush_d = br_taken;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            busy_q        <= '0;
            inflight_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_wr_q    <= '0;
            flush_q       <= 1'b0;
            wb_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            inflight_q    <= inflight_d;
            issue_valid_q <= issue_valid_d;
            issue_wr_q    <= issue_wr_d;
            flush_q       <= flush_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_wr    = issue_wr_q;
    assign flush       = flush_q;
    assign wb_err      = wb_err_q;

endmodule
